mic_array_capture_scheduler: RTL and testbench
==============================================

// Module: mic_array_capture_scheduler
// PURPOSE
// Master-mode I2S front end for the MEMS mic array. Generates MIC_SCK/MIC_WS from CLK and
// captures NUM_LINES parallel I2S data lines. At each frame end it schedules one FIFO push
// per line into a shared sample FIFO. The HPS drains the FIFO over Avalon-MM, with a
// level-threshold/overflow interrupt. Drives codec_stream from the mic or HPS-written data.
// PARAMETERS
// NUM_LINES   2   I2S data lines (stereo mic pairs); 1..8
// CLK_DIV     8   CLK cycles per SCK half-period; must be >= NUM_LINES and >= 2
// SAMPLE_BITS 16  bits kept per slot, MSB first; 1..16
// FIFO_DEPTH  16  sample FIFO entries, power of 2, <= 128
// PORTS
// CLK            in   1          system clock
// RESET          in   1          synchronous, active-high
// AVL_CS         in   1          Avalon-MM chip select
// AVL_READ       in   1          Avalon-MM read, 0 read latency
// AVL_WRITE      in   1          Avalon-MM write
// AVL_ADDR       in   4          word address
// AVL_WRITEDATA  in   32         write data
// AVL_READDATA   out  32         read data, combinational
// MIC_SD         in   NUM_LINES  I2S data, one bit per line
// MIC_SCK        out  1          I2S bit clock
// MIC_WS         out  1          I2S word select, 0 = left, 1 = right
// codec_stream   out  32         {left16,right16} to codec
// interrupt      out  1          level interrupt to HPS
// BEHAVIOUR
// Reset: all outputs 0. CTRL=0x2, THRESH=8, FIFO empty, sticky bits/counters 0, state IDLE.
// Regs: 0 CTRL rw [0]en [1]src(1=mic) [2]irq_en. 1 STATUS r [0]nonempty [1]thr_hit
//   [2]ovf [15:8]level; write bit2=1 clears ovf. 2 DATA r pops FIFO. 3 THRESH rw [7:0].
//   4 LINUX rw 32b. 5 FRAME_CNT r 32b, wraps. Unmapped reads = 0. AVL_READDATA=0 w/o CS&READ.
// FSM IDLE -> RUN when en=1 (cycle after write). RUN -> STOP when en=0. STOP -> IDLE after
//   current frame's last capture plus its pushes. In IDLE divider, bit_idx, SCK, WS held 0.
// Divider counts 0..CLK_DIV-1; SCK toggles on wrap. First SCK rise is CLK_DIV cycles into RUN.
// bit_idx 0..63 increments on every SCK fall and wraps. WS = bit_idx[5], updated at that fall.
// Sample MIC_SD on SCK rise at slot pos p = bit_idx[4:0]. Capture when 1 <= p <= SAMPLE_BITS
//   (I2S one-bit delay). Left-align to 16b, zero-fill LSBs.
// Frame end = rise at bit_idx=63. FRAME_CNT +1. If FIFO_DEPTH-level >= NUM_LINES,
//   push {L,R} of line 0..NUM_LINES-1 on the next NUM_LINES consecutive cycles.
//   Otherwise drop the whole frame and set ovf. Never push a partial frame.
// Mic latch = line 0 frame, updated at frame end, including dropped frames.
// codec_stream = src ? latch : LINUX. Takes effect the cycle after the CTRL write.
// DATA read with CS&READ: return head, pop 1 per asserted cycle. Empty: return 0, no pop.
//   Push and pop in the same cycle: level unchanged, data order kept.
// thr_hit = (THRESH!=0) && level >= THRESH.
//   interrupt = irq_en && (thr_hit || ovf), registered (1-cycle lag).
// Reset mid-frame: immediate return to the reset state, no pushes complete.
// TESTING
// Reset: outputs 0; CTRL=0x2; STATUS=0; THRESH=8; DATA read = 0.
// CLK_DIV=4, en=1: SCK period 8 CLK; WS rises on 32nd SCK fall. Drive line0 L=A5A5 R=5A5A,
//   line1 L=1234 R=FEDC. DATA reads 0xA5A55A5A then 0x1234FEDC; codec_stream=0xA5A55A5A.
// THRESH=4, irq_en=1: interrupt rises after 2nd frame (level 4); one DATA read -> falls.
// No reads for 9 frames, depth 16: level=16, ovf=1, FRAME_CNT=9, 9th frame absent.
//   Write STATUS bit2 clears ovf.
// Clear en at bit_idx=20: frame completes and is pushed. SCK/WS then 0, no further pushes.
// LINUX=0xDEADBEEF, CTRL src=0: codec_stream=0xDEADBEEF next cycle; src=1 restores latch.

Source files
------------

// File: rtl/mic_array_capture_scheduler.sv
// Master-mode I2S capture for a MEMS mic array: SCK/WS generation, per-line slot capture,
// frame-atomic scheduling into a shared sample FIFO, and an Avalon-MM register window.

module mic_capture_lane (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cap_en,
  input  logic        slot,
  input  logic [4:0]  pos,
  input  logic        sd,
  output logic [31:0] word
);
  // pos 1 lands on bit 15 of its half; bits below SAMPLE_BITS are never written and stay 0
  logic [3:0] bit_n;
  assign bit_n = 4'(5'd16 - pos);

  always_ff @(posedge CLK) begin
    if (RESET)       word <= '0;
    else if (cap_en) word[{~slot, bit_n}] <= sd;
  end
endmodule

module mic_array_capture_scheduler #(
  parameter int NUM_LINES   = 2,
  parameter int CLK_DIV     = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 AVL_CS,
  input  logic                 AVL_READ,
  input  logic                 AVL_WRITE,
  input  logic [3:0]           AVL_ADDR,
  input  logic [31:0]          AVL_WRITEDATA,
  output logic [31:0]          AVL_READDATA,
  input  logic [NUM_LINES-1:0] MIC_SD,
  output logic                 MIC_SCK,
  output logic                 MIC_WS,
  output logic [31:0]          codec_stream,
  output logic                 interrupt
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [4:0] SB = 5'(SAMPLE_BITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } avl_req_t;

  avl_req_t req;
  assign req.rd    = AVL_CS && AVL_READ;
  assign req.wr    = AVL_CS && AVL_WRITE;
  assign req.addr  = AVL_ADDR;
  assign req.wdata = AVL_WRITEDATA;

  state_t      state;
  logic        ctrl_en, ctrl_src, ctrl_irq_en;
  logic [7:0]  thresh;
  logic [31:0] linux_reg, frame_cnt, mic_latch;
  logic        ovf, irq, push_ok;

  logic [DIV_W-1:0] div_cnt;
  logic             sck, ws;
  logic [5:0]       bit_idx, bit_idx_inc;

  logic [NUM_LINES-1:0][31:0] lane_word;
  logic [NUM_LINES:0]         vld_pipe;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W:0]   room;

  logic        wr_ctrl, en_nxt, div_wrap, sck_rise, sck_fall, frame_end, cap_en;
  logic        room_ok, push, pop, thr_hit;
  logic [31:0] push_data;

  assign wr_ctrl     = req.wr && (req.addr == 4'd0);
  assign en_nxt      = wr_ctrl ? req.wdata[0] : ctrl_en;
  assign div_wrap    = (state != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise    = div_wrap && !sck;
  assign sck_fall    = div_wrap && sck;
  assign bit_idx_inc = bit_idx + 6'd1;
  assign frame_end   = sck_rise && (bit_idx == 6'd63);
  // slot position 0 is the I2S one-bit delay after the WS edge
  assign cap_en      = sck_rise && (bit_idx[4:0] != 5'd0) && (bit_idx[4:0] <= SB);
  assign room        = (LVL_W+1)'(FIFO_DEPTH) - (LVL_W+1)'(level);
  assign room_ok     = room >= (LVL_W+1)'(NUM_LINES);
  assign pop         = req.rd && (req.addr == 4'd2) && (level != '0);
  assign thr_hit     = (thresh != 8'd0) && (8'(level) >= thresh);

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_lane
    mic_capture_lane u_lane (
      .CLK    (CLK),
      .RESET  (RESET),
      .cap_en (cap_en),
      .slot   (bit_idx[5]),
      .pos    (bit_idx[4:0]),
      .sd     (MIC_SD[g]),
      .word   (lane_word[g])
    );
  end

  // one line per cycle after frame end; lane words stay stable until the next slot's captures
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (vld_pipe[k] && push_ok) begin
        push      = 1'b1;
        push_data = lane_word[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else begin
      unique case (state)
        S_IDLE:  if (en_nxt) state <= S_RUN;
        S_RUN:   if (!en_nxt) state <= S_STOP;
        S_STOP:  if (vld_pipe[NUM_LINES]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || state == S_IDLE) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_idx <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) sck <= ~sck;
      if (sck_fall) begin
        bit_idx <= bit_idx_inc;
        ws      <= bit_idx_inc[5];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RESET) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_en     <= 1'b0;
      ctrl_src    <= 1'b1;
      ctrl_irq_en <= 1'b0;
      thresh      <= 8'd8;
      linux_reg   <= '0;
      frame_cnt   <= '0;
      mic_latch   <= '0;
      ovf         <= 1'b0;
      irq         <= 1'b0;
      push_ok     <= 1'b0;
      vld_pipe    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= req.wdata[0];
        ctrl_src    <= req.wdata[1];
        ctrl_irq_en <= req.wdata[2];
      end
      if (req.wr && req.addr == 4'd3) thresh    <= req.wdata[7:0];
      if (req.wr && req.addr == 4'd4) linux_reg <= req.wdata;

      vld_pipe <= {vld_pipe[NUM_LINES-1:0], frame_end};
      if (frame_end) begin
        frame_cnt <= frame_cnt + 32'd1;
        mic_latch <= lane_word[0];
        push_ok   <= room_ok;
      end
      // a drop and a clear in the same cycle leave the flag set
      if (frame_end && !room_ok)                         ovf <= 1'b1;
      else if (req.wr && req.addr == 4'd1 && req.wdata[2]) ovf <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
      irq   <= ctrl_irq_en && (thr_hit || ovf);
    end
  end

  always_comb begin
    AVL_READDATA = '0;
    if (req.rd) begin
      unique case (req.addr)
        4'd0:    AVL_READDATA = {29'd0, ctrl_irq_en, ctrl_src, ctrl_en};
        4'd1:    AVL_READDATA = {16'd0, 8'(level), 5'd0, ovf, thr_hit, level != '0};
        4'd2:    AVL_READDATA = (level != '0) ? mem[rd_ptr] : 32'd0;
        4'd3:    AVL_READDATA = {24'd0, thresh};
        4'd4:    AVL_READDATA = linux_reg;
        4'd5:    AVL_READDATA = frame_cnt;
        default: AVL_READDATA = '0;
      endcase
    end
  end

  assign MIC_SCK      = sck;
  assign MIC_WS       = ws;
  assign codec_stream = ctrl_src ? mic_latch : linux_reg;
  assign interrupt    = irq;
endmodule

// File: tb/tb_mic_array_capture_scheduler.sv
// Directed bench: an I2S line transmitter driven off MIC_SCK, a queue of expected FIFO words
// filled at each frame boundary, and register/output checks along one linear sequence.

module tb_mic_array_capture_scheduler;
  logic        CLK, RESET;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic [1:0]  MIC_SD;
  logic        MIC_SCK, MIC_WS, interrupt;
  logic [31:0] codec_stream;

  mic_array_capture_scheduler #(
    .NUM_LINES(2), .CLK_DIV(4), .SAMPLE_BITS(16), .FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .MIC_SD(MIC_SD), .MIC_SCK(MIC_SCK), .MIC_WS(MIC_WS),
    .codec_stream(codec_stream), .interrupt(interrupt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0, errors = 0;
  logic [15:0] tx_l [2], tx_r [2];
  logic [5:0]  tx_bit;
  int          tx_frames, seen_frames, exp_frames;
  logic [31:0] exp_q [$];
  logic [31:0] exp_latch, rd;
  int          n, c0, c1;
  logic        prev_sck;

  // I2S transmitter: bit position advances on each SCK fall, MSB one bit after the WS edge
  initial begin
    MIC_SD    = '0;
    tx_bit    = '0;
    tx_frames = 0;
    @(negedge RESET);
    forever begin
      @(negedge MIC_SCK);
      tx_bit = tx_bit + 6'd1;
      if (tx_bit == 6'd0) tx_frames++;
      for (int k = 0; k < 2; k++) begin
        logic [15:0] w;
        int p;
        w = tx_bit[5] ? tx_r[k] : tx_l[k];
        p = int'(tx_bit[4:0]);
        MIC_SD[k] = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic avl_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    #1 d = AVL_READDATA;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    e = exp_q.pop_front();
    avl_rd(4'd2, d);
    check(tag, d, e);
  endtask

  // Waits for the next frame boundary and records what the FIFO should now hold
  task automatic wait_frame();
    int cyc = 0;
    while (tx_frames <= seen_frames && cyc < 3000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("frame_seen", tx_frames, seen_frames + 1);
    seen_frames++;
    exp_frames++;
    exp_latch = {tx_l[0], tx_r[0]};
    if (16 - exp_q.size() >= 2) begin
      exp_q.push_back({tx_l[0], tx_r[0]});
      exp_q.push_back({tx_l[1], tx_r[1]});
    end
  endtask

  task automatic set_data(input int i);
    tx_l[0] = 16'(16'h1100 + i); tx_r[0] = 16'(16'h2200 + i);
    tx_l[1] = 16'(16'h3300 + i); tx_r[1] = 16'(16'h4400 + i);
  endtask

  initial begin
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = '0; AVL_WRITEDATA = '0;
    seen_frames = 0; exp_frames = 0; exp_latch = '0;
    tx_l[0] = 16'hA5A5; tx_r[0] = 16'h5A5A; tx_l[1] = 16'h1234; tx_r[1] = 16'hFEDC;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // reset state
    check("rst_sck", MIC_SCK, 0);
    check("rst_ws", MIC_WS, 0);
    check("rst_codec", codec_stream, 0);
    check("rst_irq", interrupt, 0);
    check("rst_rdata_nocs", AVL_READDATA, 0);
    avl_rd(4'd0, rd); check("rst_ctrl", rd, 32'h2);
    avl_rd(4'd1, rd); check("rst_status", rd, 32'h0);
    avl_rd(4'd3, rd); check("rst_thresh", rd, 32'h8);
    avl_rd(4'd2, rd); check("rst_data_empty", rd, 32'h0);
    avl_rd(4'd5, rd); check("rst_frame_cnt", rd, 32'h0);
    avl_rd(4'd7, rd); check("unmapped", rd, 32'h0);

    // run: WS rises on the 32nd SCK fall, SCK period is 2*CLK_DIV
    avl_wr(4'd0, 32'h3);
    n = 0; prev_sck = MIC_SCK;
    for (int cyc = 0; cyc < 2000 && MIC_WS !== 1'b1; cyc++) begin
      @(negedge CLK);
      if (prev_sck === 1'b1 && MIC_SCK === 1'b0) n++;
      prev_sck = MIC_SCK;
    end
    check("ws_fall_count", n, 32);
    c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 100 && MIC_SCK !== 1'b0; cyc++) @(negedge CLK);
    for (int cyc = 0; cyc < 100 && MIC_SCK !== 1'b1; cyc++) @(negedge CLK);
    while (MIC_SCK === 1'b1 && c0 < 100) begin @(negedge CLK); c0++; end
    while (MIC_SCK === 1'b0 && c1 < 100) begin @(negedge CLK); c1++; end
    check("sck_period", c0 + c1, 8);

    wait_frame();
    avl_rd(4'd5, rd); check("frame_cnt_1", rd, exp_frames);
    check("codec_mic", codec_stream, exp_latch);
    pop_check("data_line0");
    pop_check("data_line1");

    // threshold interrupt
    avl_wr(4'd3, 32'h4);
    avl_wr(4'd0, 32'h7);
    wait_frame();
    check("irq_below_thr", interrupt, 0);
    avl_rd(4'd1, rd); check("status_lvl2", rd, 32'h0201);
    wait_frame();
    check("irq_at_thr", interrupt, 1);
    avl_rd(4'd1, rd); check("status_lvl4", rd, 32'h0403);
    pop_check("data_irq_pop");
    @(posedge CLK); #1;
    check("irq_after_pop", interrupt, 0);
    repeat (3) pop_check("data_irq_drain");

    // stop mid-frame: the frame still completes and is pushed
    for (int cyc = 0; cyc < 2000 && tx_bit != 6'd20; cyc++) @(negedge CLK);
    avl_wr(4'd0, 32'h2);
    wait_frame();
    repeat (20) @(posedge CLK); #1;
    check("stop_sck", MIC_SCK, 0);
    check("stop_ws", MIC_WS, 0);
    avl_rd(4'd1, rd); check("stop_status", rd, 32'h0201);
    repeat (600) @(posedge CLK); #1;
    avl_rd(4'd1, rd); check("stop_no_push", rd, 32'h0201);
    check("stop_no_frame", tx_frames, seen_frames);
    repeat (2) pop_check("data_stop");

    // fresh reset, then nine unread frames into a 16-deep FIFO
    @(negedge CLK) RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    exp_frames = 0; exp_latch = '0;
    avl_rd(4'd5, rd); check("rst2_frame_cnt", rd, 32'h0);
    check("rst2_codec", codec_stream, exp_latch);
    set_data(0);
    avl_wr(4'd0, 32'h3);
    for (int i = 0; i < 9; i++) begin
      wait_frame();
      set_data(i + 1);
    end
    avl_rd(4'd1, rd); check("ovf_status", rd, 32'h1007);
    avl_rd(4'd5, rd); check("ovf_frame_cnt", rd, 32'd9);
    check("ovf_irq_disabled", interrupt, 0);
    avl_wr(4'd1, 32'h4);
    avl_rd(4'd1, rd); check("ovf_cleared", rd, 32'h1003);

    // codec source switch; latch holds the dropped ninth frame
    avl_wr(4'd4, 32'hDEADBEEF);
    check("codec_latch_dropped", codec_stream, exp_latch);
    avl_wr(4'd0, 32'h1);
    check("codec_linux", codec_stream, 32'hDEADBEEF);
    avl_wr(4'd0, 32'h3);
    check("codec_restore", codec_stream, exp_latch);

    while (exp_q.size() > 0) pop_check("data_ovf_drain");
    avl_rd(4'd1, rd); check("final_status", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
